// File: rtl/wave_channel_gen.sv
// Wave-table sound channel: plays 4-bit samples from banked wave RAM at a
// programmable rate, with length counter, volume shifter and DAC gating.
module wave_channel_gen #(
  parameter int unsigned NSAMPLES = 32,
  parameter int unsigned NBANKS   = 1,
  parameter int unsigned FREQ_W   = 11,
  parameter int unsigned LEN_W    = 8,
  localparam int unsigned AW = $clog2(NBANKS * NSAMPLES / 2),
  localparam int unsigned IW = $clog2(NSAMPLES)
) (
  input  logic              cery_2mhz,
  input  logic              apu_reset,
  input  logic              tick_256hz,
  input  logic              dac_en,
  input  logic              trig,
  input  logic              len_en,
  input  logic              len_load,
  input  logic [LEN_W-1:0]  len_val,
  input  logic [FREQ_W-1:0] freq,
  input  logic [1:0]        vol_code,
  input  logic              bank_sel,
  input  logic              chain,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              active,
  output logic [3:0]        sample_out,
  output logic [IW:0]       pos
);

  localparam int unsigned     DEPTH   = NBANKS * NSAMPLES / 2;
  localparam logic [LEN_W:0]  LC_FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]  LC_ONE  = {{LEN_W{1'b0}}, 1'b1};

  logic [7:0]        mem [DEPTH];
  logic [IW-1:0]     idx;
  logic              play_bank;
  logic              chain_l;
  logic [FREQ_W-1:0] ft;
  logic [LEN_W:0]    lc;
  logic [3:0]        sample_buf;

  logic              trig_go;
  logic              ft_wrap;
  logic              len_tick;
  logic              len_expire;
  logic              cpu_bank;
  logic              cpu_busy;
  logic              next_bank;
  logic [IW-1:0]     next_idx;
  logic [AW-1:0]     fetch_addr;
  logic [7:0]        fetch_byte;
  logic [3:0]        fetch_nib;

  generate
    if (NBANKS == 2) begin : g_two_banks
      assign cpu_bank   = cpu_addr[AW-1];
      assign fetch_addr = {next_bank, next_idx[IW-1:1]};
    end else begin : g_one_bank
      assign cpu_bank   = 1'b0;
      assign fetch_addr = next_idx[IW-1:1];
    end
  endgenerate

  always_comb begin
    trig_go    = trig && dac_en;
    ft_wrap    = (ft == '1);
    next_idx   = idx + 1'b1;
    next_bank  = play_bank ^ (chain_l && (idx == '1));
    len_tick   = tick_256hz && len_en && (lc != '0) && !len_load && !trig_go;
    len_expire = len_tick && (lc == LC_ONE);
    cpu_busy   = active && (chain_l || (cpu_bank == play_bank));
    fetch_byte = mem[fetch_addr];
    fetch_nib  = next_idx[0] ? fetch_byte[3:0] : fetch_byte[7:4];
  end

  always_comb begin
    sample_out = '0;
    if (active) begin
      case (vol_code)
        2'd1:    sample_out = sample_buf;
        2'd2:    sample_out = sample_buf >> 1;
        2'd3:    sample_out = sample_buf >> 2;
        default: sample_out = '0;
      endcase
    end
  end

  assign pos = {play_bank, idx};

  always_ff @(posedge cery_2mhz) begin
    if (apu_reset) begin
      active     <= 1'b0;
      idx        <= '0;
      play_bank  <= 1'b0;
      chain_l    <= 1'b0;
      ft         <= '0;
      lc         <= '0;
      sample_buf <= '0;
      cpu_rdata  <= '0;
    end else begin
      if (len_load) begin
        lc <= LC_FULL - {1'b0, len_val};
      end else if (trig_go) begin
        if (lc == '0) lc <= LC_FULL;
      end else if (len_tick) begin
        lc <= lc - LC_ONE;
      end

      if (!dac_en) begin
        active <= 1'b0;
      end else if (trig) begin
        active <= 1'b1;
      end else if (len_expire) begin
        active <= 1'b0;
      end

      // A trigger restarts the sequence without fetching; the old sample_buf keeps playing.
      if (trig_go) begin
        idx       <= '0;
        ft        <= freq;
        play_bank <= (NBANKS == 2) && bank_sel;
        chain_l   <= (NBANKS == 2) && chain;
      end else if (active) begin
        if (ft_wrap) begin
          ft         <= freq;
          idx        <= next_idx;
          play_bank  <= next_bank;
          sample_buf <= fetch_nib;
        end else begin
          ft <= ft + 1'b1;
        end
      end

      if (cpu_re) cpu_rdata <= cpu_busy ? 8'hFF : mem[cpu_addr];
    end
  end

  always_ff @(posedge cery_2mhz) begin
    if (cpu_we && !cpu_busy && !apu_reset) mem[cpu_addr] <= cpu_wdata;
  end

endmodule

// File: tb/tb_wave_channel_gen.sv
// Scoreboard bench for wave_channel_gen (NBANKS=2): a cycle-level reference
// model queues expected outputs; a monitor pops and compares after each edge.
module tb_wave_channel_gen;

  localparam int NS = 32;
  localparam int NB = 2;
  localparam int FW = 11;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          apu_reset;
  logic          tick_256hz;
  logic          dac_en;
  logic          trig;
  logic          len_en;
  logic          len_load;
  logic [LW-1:0] len_val;
  logic [FW-1:0] freq;
  logic [1:0]    vol_code;
  logic          bank_sel;
  logic          chain;
  logic          cpu_we;
  logic          cpu_re;
  logic [4:0]    cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          active;
  logic [3:0]    sample_out;
  logic [5:0]    pos;

  wave_channel_gen #(
    .NSAMPLES(NS),
    .NBANKS  (NB),
    .FREQ_W  (FW),
    .LEN_W   (LW)
  ) dut (
    .cery_2mhz (clk),
    .apu_reset (apu_reset),
    .tick_256hz(tick_256hz),
    .dac_en    (dac_en),
    .trig      (trig),
    .len_en    (len_en),
    .len_load  (len_load),
    .len_val   (len_val),
    .freq      (freq),
    .vol_code  (vol_code),
    .bank_sel  (bank_sel),
    .chain     (chain),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .active    (active),
    .sample_out(sample_out),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int act;
    int pos;
    int smp;
    int rd;
    int ph;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   phase = 0;

  // Reference model: sample position as plain integers, a countdown of
  // cycles to the next advance, and a byte array mirroring the wave RAM.
  bit         m_active;
  int         m_idx, m_bank, m_chain, m_cnt, m_lc, m_buf, m_rd;
  logic [7:0] m_ram [NB*NS/2];

  task automatic model_step();
    bit go, busy, expire;
    int a, b8;
    if (apu_reset) begin
      m_active = 0; m_idx = 0; m_bank = 0; m_chain = 0;
      m_cnt = 0; m_lc = 0; m_buf = 0; m_rd = 0;
      return;
    end
    a    = int'(cpu_addr);
    busy = m_active && (m_chain != 0 || (a / (NS/2)) == m_bank);
    if (cpu_re) m_rd = busy ? 255 : int'(m_ram[a]);
    if (cpu_we && !busy) m_ram[a] = cpu_wdata;

    go = trig && dac_en;
    if (go) begin
      m_idx   = 0;
      m_cnt   = (1 << FW) - int'(freq);
      m_bank  = int'(bank_sel);
      m_chain = int'(chain);
    end else if (m_active) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_cnt = (1 << FW) - int'(freq);
        m_idx++;
        if (m_idx == NS) begin
          m_idx = 0;
          if (m_chain != 0) m_bank = 1 - m_bank;
        end
        b8    = int'(m_ram[m_bank*(NS/2) + m_idx/2]);
        m_buf = (m_idx % 2 == 0) ? (b8 >> 4) : (b8 & 15);
      end
    end

    expire = 0;
    if (len_load) begin
      m_lc = (1 << LW) - int'(len_val);
    end else if (go) begin
      if (m_lc == 0) m_lc = 1 << LW;
    end else if (tick_256hz && len_en && m_lc != 0) begin
      m_lc--;
      if (m_lc == 0) expire = 1;
    end

    if (!dac_en)     m_active = 0;
    else if (trig)   m_active = 1;
    else if (expire) m_active = 0;
  endtask

  task automatic issue();
    exp_t e;
    model_step();
    e.act = m_active ? 1 : 0;
    e.pos = m_bank * NS + m_idx;
    e.smp = (m_active && vol_code != 0) ? (m_buf >> (int'(vol_code) - 1)) : 0;
    e.rd  = m_rd;
    e.ph  = phase;
    q.push_back(e);
    @(posedge clk);
    #2;
    trig = 1'b0; len_load = 1'b0; tick_256hz = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) issue();
  endtask

  task automatic wr(input int a, input int d);
    cpu_we = 1'b1; cpu_addr = a[4:0]; cpu_wdata = d[7:0];
    issue();
  endtask

  task automatic rd(input int a);
    cpu_re = 1'b1; cpu_addr = a[4:0];
    issue();
  endtask

  task automatic chk(input string nm, input int ph, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s phase %0d t=%0t: got %0d expected %0d", nm, ph, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("active",     e.ph, int'(active),     e.act);
        chk("pos",        e.ph, int'(pos),        e.pos);
        chk("sample_out", e.ph, int'(sample_out), e.smp);
        chk("cpu_rdata",  e.ph, int'(cpu_rdata),  e.rd);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    apu_reset = 1'b1; tick_256hz = 1'b0; dac_en = 1'b0; trig = 1'b0;
    len_en = 1'b0; len_load = 1'b0; len_val = '0; freq = '0; vol_code = '0;
    bank_sel = 1'b0; chain = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;

    phase = 0;
    idle(3);
    apu_reset = 1'b0;
    for (int i = 0; i < NB*NS/2; i++) wr(i, (i == 0) ? 8'h4F : int'($urandom_range(0, 255)));
    for (int i = 0; i < NB*NS/2; i += 5) rd(i);

    phase = 1;
    dac_en = 1'b1; vol_code = 2'd1; freq = 11'd2046; bank_sel = 1'b0; chain = 1'b0;
    trig = 1'b1; issue();
    idle(6);

    phase = 2;
    dac_en = 1'b0; issue();
    dac_en = 1'b1;
    wr(0, 8'h4E);
    freq = 11'd2046; trig = 1'b1; issue();
    freq = 11'd0;
    idle(2);
    for (int v = 0; v < 4; v++) begin
      vol_code = v[1:0];
      idle(2);
    end

    phase = 3;
    dac_en = 1'b0; issue();
    dac_en = 1'b1; len_en = 1'b1; len_val = 8'd254; len_load = 1'b1; issue();
    trig = 1'b1; issue();
    idle(3);
    tick_256hz = 1'b1; issue();
    idle(2);
    tick_256hz = 1'b1; issue();
    idle(2);
    trig = 1'b1; issue();
    repeat (255) begin
      tick_256hz = 1'b1; issue();
    end
    idle(1);
    tick_256hz = 1'b1; issue();
    idle(2);

    phase = 4;
    len_en = 1'b0; vol_code = 2'd1; freq = 11'd2000; bank_sel = 1'b0; chain = 1'b0;
    trig = 1'b1; issue();
    wr(3, 8'hAA);
    rd(3);
    wr(18, 8'hAA);
    rd(18);
    dac_en = 1'b0; issue();
    dac_en = 1'b1;
    rd(3);
    rd(18);

    phase = 5;
    bank_sel = 1'b0; chain = 1'b1; freq = 11'd2047;
    trig = 1'b1; issue();
    for (int n = 0; n < 140; n++) begin
      if (n % 9 == 0) rd(int'($urandom_range(0, 31)));
      else issue();
    end
    chain = 1'b0;

    phase = 6;
    dac_en = 1'b0; issue();
    dac_en = 1'b1; len_en = 1'b1; len_val = 8'd255; len_load = 1'b1; issue();
    trig = 1'b1; tick_256hz = 1'b1; issue();
    idle(2);
    tick_256hz = 1'b1; issue();
    idle(1);
    freq = 11'd2040; bank_sel = 1'b1;
    trig = 1'b1; issue();
    idle(20);
    apu_reset = 1'b1; issue();
    apu_reset = 1'b0;
    idle(2);
    for (int i = 0; i < NB*NS/2; i++) rd(i);

    phase = 7;
    for (int n = 0; n < 2500; n++) begin
      dac_en     = ($urandom_range(0, 49) != 0);
      trig       = ($urandom_range(0, 39) == 0);
      tick_256hz = ($urandom_range(0, 7) == 0);
      len_en     = 1'($urandom_range(0, 1));
      len_load   = ($urandom_range(0, 59) == 0);
      len_val    = LW'($urandom_range(200, 255));
      if ($urandom_range(0, 19) == 0)
        freq = ($urandom_range(0, 3) == 0) ? FW'($urandom_range(0, 2047))
                                           : FW'($urandom_range(2035, 2047));
      vol_code   = 2'($urandom_range(0, 3));
      bank_sel   = 1'($urandom_range(0, 1));
      chain      = 1'($urandom_range(0, 1));
      cpu_we     = ($urandom_range(0, 3) == 0);
      cpu_re     = ($urandom_range(0, 2) == 0);
      cpu_addr   = 5'($urandom_range(0, 31));
      cpu_wdata  = 8'($urandom_range(0, 255));
      apu_reset  = ($urandom_range(0, 499) == 0);
      issue();
    end
    apu_reset = 1'b0;
    idle(2);

    for (int w = 0; w < 10 && q.size() != 0; w++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
